// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: a registered one-hot grant, plus the
// binary select of the current owner, with an optional burst limit on how long one owner may hold.
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] select,
   output logic       busy
);

   typedef enum logic {IDLE, OWNED} state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   state_t            state;
   logic [1:0]        ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic [1:0] rot_ptr;
   logic [3:0] others;
   logic [1:0] pass_idx;
   logic [1:0] idle_idx;
   logic       at_limit;

   // Returns the first set bit of r, scanning from index p and wrapping modulo 4.
   function automatic logic [1:0] first_req(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      first_req = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) first_req = idx;
      end
   endfunction

   // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      rot_ptr  = select + 2'd1;
      others   = req & ~(4'b0001 << select);
      pass_idx = first_req(others, rot_ptr);
      idle_idx = first_req(req, ptr);
      at_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         select   <= '0;
         busy     <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state    <= OWNED;
                  gnt      <= 4'b0001 << idle_idx;
                  select   <= idle_idx;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            OWNED: begin
               if (!req[select]) begin
                  // Owner released: hand over on the same edge when anyone else is waiting.
                  ptr <= rot_ptr;
                  if (|others) begin
                     gnt      <= 4'b0001 << pass_idx;
                     select   <= pass_idx;
                     hold_cnt <= '0;
                  end else begin
                     state <= IDLE;
                     gnt   <= '0;
                     busy  <= 1'b0;
                  end
               end else if (at_limit) begin
                  hold_cnt <= '0;
                  if (|others) begin
                     ptr    <= rot_ptr;
                     gnt    <= 4'b0001 << pass_idx;
                     select <= pass_idx;
                  end
               end else if (!(MAX_HOLD == 0 && (&hold_cnt))) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a tenure-based reference model queues the expected outputs
// for every edge, and an independent monitor compares them against the DUT one cycle later.
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] select;
   logic       busy;

   typedef struct {
      int gnt;
      int sel;
      int busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: owner index (-1 = idle), priority start, and cycles owned so far.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_ten   = 0;
   int m_sel   = 0;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .gnt    (gnt),
      .select (select),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int first_of(input int r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic model_step(input int r, input bit rst);
      int o;
      int oth;
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_ten = 0; m_sel = 0;
      end else if (m_owner < 0) begin
         if (r != 0) begin
            m_owner = first_of(r, m_ptr);
            m_ten   = 1;
         end
      end else begin
         o   = m_owner;
         oth = r & ~(1 << o);
         if (!r[o]) begin
            m_ptr = (o + 1) % 4;
            if (oth != 0) begin
               m_owner = first_of(oth, m_ptr);
               m_ten   = 1;
            end else begin
               m_owner = -1;
            end
         end else if (MAX_HOLD > 0 && m_ten == MAX_HOLD) begin
            m_ten = 1;
            if (oth != 0) begin
               m_ptr   = (o + 1) % 4;
               m_owner = first_of(oth, m_ptr);
            end
         end else begin
            m_ten++;
         end
      end
      if (m_owner >= 0) m_sel = m_owner;
   endtask

   // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
   task automatic cycle(input logic [3:0] r, input logic rst);
      exp_t e;
      @(negedge clk);
      req   = r;
      reset = rst;
      model_step(int'(r), rst);
      e.gnt  = (m_owner < 0) ? 0 : (1 << m_owner);
      e.sel  = m_sel;
      e.busy = (m_owner >= 0) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt", int'(gnt), e.gnt);
            check("select", int'(select), e.sel);
            check("busy", int'(busy), e.busy);
         end
      end
   end

   initial begin : stimulus
      logic [3:0] r;
      reset = 1'b1;
      req   = 4'b0000;

      // Single requester, then release: select must stay on the last owner.
      cycle(4'b0000, 1'b1);
      repeat (5) cycle(4'b0001, 1'b0);
      repeat (3) cycle(4'b0000, 1'b0);

      // Two requesters, first owner drops with no idle gap.
      cycle(4'b0000, 1'b1);
      repeat (3) cycle(4'b0110, 1'b0);
      repeat (4) cycle(4'b0100, 1'b0);
      cycle(4'b0000, 1'b0);

      // All requesting, each owner releases after two cycles and re-raises.
      cycle(4'b0000, 1'b1);
      for (int i = 0; i < 24; i++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_ten >= 2) r[m_owner] = 1'b0;
         cycle(r, 1'b0);
      end

      // Burst limit alternation between two persistent requesters.
      cycle(4'b0000, 1'b1);
      repeat (40) cycle(4'b0011, 1'b0);

      // Lone requester is never forced off at the limit.
      cycle(4'b0000, 1'b1);
      repeat (20) cycle(4'b0100, 1'b0);

      // Reset in the middle of a grant restores priority to index 0.
      repeat (3) cycle(4'b1111, 1'b0);
      cycle(4'b1111, 1'b1);
      repeat (3) cycle(4'b1111, 1'b0);

      // Randomized requests with occasional reset.
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         cycle(r, ($urandom_range(0, 59) == 0));
      end
      cycle(4'b0000, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      check("drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
